// File: rtl/sram_req_ctrl.sv
// Single-outstanding request controller in front of a single-port synchronous SRAM
// with a shared tri-state data bus; every output is registered by the FSM below.
module sram_req_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_is_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire logic [DATA_WIDTH-1:0] ram_data,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RSP      = 3'd4
    } state_t;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // req_ready is high only in IDLE, rsp_valid only in RSP.

    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares without wrap-around.
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_is_wr;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic                  r_ram_cs;
    logic                  r_ram_we;
    logic                  r_ram_oe;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic w_addr_err;
    logic w_accept;

    assign w_addr_err = ({1'b0, req_addr} >= LP_DEPTH);
    assign w_accept   = req_valid && r_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_is_wr <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_oe    <= 1'b0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_wdata     <= req_wdata;
                        r_rsp_is_wr <= req_we;
                        if (w_addr_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_state     <= S_RSP;
                        end else begin
                            r_ram_addr <= req_addr;
                            r_ram_cs   <= 1'b1;
                            r_ram_we   <= req_we;
                            r_state    <= req_we ? S_WR : S_RD_ISSUE;
                        end
                    end
                end
                S_WR: begin
                    r_ram_cs    <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                S_RD_ISSUE: begin
                    r_ram_oe <= 1'b1;
                    r_state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_ram_cs    <= 1'b0;
                    r_ram_oe    <= 1'b0;
                    r_rsp_rdata <= ram_data;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_is_wr <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ram_we is high only in WR, so the bus is driven only while the RAM is being written.
    assign ram_data  = r_ram_we ? r_wdata : {DATA_WIDTH{1'bz}};

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign rsp_is_wr = r_rsp_is_wr;
    assign ram_addr  = r_ram_addr;
    assign ram_cs    = r_ram_cs;
    assign ram_we    = r_ram_we;
    assign ram_oe    = r_ram_oe;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: directed vector table, reset/abort and busy-toggle sequences,
// and a random read/write mix checked against a shadow memory, with a small RAM model on the bus.
module tb_sram_req_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_is_wr;
    logic [3:0]  ram_addr;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_oe;
    wire  [31:0] ram_data;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    sram_req_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_is_wr (rsp_is_wr),
        .ram_addr  (ram_addr),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_data  (ram_data),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // synchronous single-port RAM model, output enabled by ram_oe
    logic [31:0] mem [16] = '{default: 32'hC0DE0000};
    logic [31:0] r_q = 32'h0;
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        if (ram_cs && !ram_we) r_q <= mem[ram_addr];
    end
    assign ram_data = ram_oe ? r_q : 32'hzzzzzzzz;

    logic [31:0] shadow [16] = '{default: 32'hC0DE0000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // bus-control sanity every cycle outside reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("bus_oe_excl", {31'b0, ram_oe && (ram_we || !ram_cs)}, 32'h0);
            chk("bus_idle_ctl", {31'b0, !ram_cs && (ram_we || ram_oe)}, 32'h0);
        end
    end

    // driver: one complete transaction, entered and left at a negedge
    task automatic run_txn(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                           input int hold, input logic exp_err, input logic [31:0] exp_rdata,
                           input int exp_lat, input bit chk_b2b, input string nm);
        int wait_cyc;
        int lat;
        bit cs_seen;
        bit got_rsp;
        logic [31:0] held_rdata;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        wait_cyc  = 0;
        while (!req_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!req_ready) begin
            chk({nm, "_accept_timeout"}, 32'h0, 32'h1);
            req_valid = 1'b0;
            return;
        end
        if (chk_b2b) chk({nm, "_b2b_wait"}, wait_cyc, 0);
        exp_q.push_back(exp_rdata);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 4'($urandom);
        req_wdata = $urandom;
        lat = 1;
        cs_seen = 1'b0;
        got_rsp = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ram_cs) begin
                cs_seen = 1'b1;
                chk({nm, "_ram_addr"}, {28'b0, ram_addr}, {28'b0, addr});
            end
            if (ram_we) chk({nm, "_ram_wdata"}, ram_data, wdata);
            if (rsp_valid) begin
                got_rsp = 1'b1;
                break;
            end
            chk({nm, "_busy_ready"}, {31'b0, req_ready}, 32'h0);
            lat++;
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom);
            req_addr  = 4'($urandom);
            req_wdata = $urandom;
        end
        req_valid = 1'b0;
        if (!got_rsp) begin
            chk({nm, "_rsp_timeout"}, 32'h0, 32'h1);
            void'(exp_q.pop_front());
            return;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        chk({nm, "_is_wr"}, {31'b0, rsp_is_wr}, {31'b0, we});
        chk({nm, "_rdata"}, rsp_rdata, exp_q.pop_front());
        chk({nm, "_cs_seen"}, {31'b0, cs_seen}, {31'b0, !exp_err});
        held_rdata = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, {31'b0, rsp_valid}, 32'h1);
            chk({nm, "_hold_rdata"}, rsp_rdata, held_rdata);
            chk({nm, "_hold_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
            chk({nm, "_hold_ready"}, {31'b0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_back_idle"}, {29'b0, dbg_state}, 32'h0);
        chk({nm, "_back_ready"}, {31'b0, req_ready}, 32'h1);
        chk({nm, "_rsp_dropped"}, {31'b0, rsp_valid}, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req_ready"}, {31'b0, req_ready}, 32'h0);
        chk({nm, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
        chk({nm, "_rsp_err"}, {31'b0, rsp_err}, 32'h0);
        chk({nm, "_rsp_is_wr"}, {31'b0, rsp_is_wr}, 32'h0);
        chk({nm, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({nm, "_ram_ctl"}, {29'b0, ram_cs, ram_we, ram_oe}, 32'h0);
        chk({nm, "_ram_addr"}, {28'b0, ram_addr}, 32'h0);
        chk({nm, "_state"}, {29'b0, dbg_state}, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 0, 1'b0, 32'h00000000, 2};
        vecs[1]  = '{1'b0, 4'd3,  32'h00000000, 0, 1'b0, 32'hDEADBEEF, 3};
        vecs[2]  = '{1'b1, 4'd7,  32'h00000001, 0, 1'b0, 32'h00000000, 2};
        vecs[3]  = '{1'b0, 4'd8,  32'h00000000, 0, 1'b1, 32'h00000000, 1};
        vecs[4]  = '{1'b0, 4'd7,  32'h00000000, 0, 1'b0, 32'h00000001, 3};
        vecs[5]  = '{1'b1, 4'd0,  32'hA5A5A5A5, 0, 1'b0, 32'h00000000, 2};
        vecs[6]  = '{1'b0, 4'd0,  32'h00000000, 0, 1'b0, 32'hA5A5A5A5, 3};
        vecs[7]  = '{1'b1, 4'd15, 32'h12345678, 0, 1'b1, 32'h00000000, 1};
        vecs[8]  = '{1'b0, 4'd15, 32'h00000000, 0, 1'b1, 32'h00000000, 1};
        vecs[9]  = '{1'b1, 4'd8,  32'hFFFFFFFF, 0, 1'b1, 32'h00000000, 1};
        vecs[10] = '{1'b0, 4'd3,  32'h00000000, 0, 1'b0, 32'hDEADBEEF, 3};
        vecs[11] = '{1'b0, 4'd5,  32'h00000000, 0, 1'b0, 32'hC0DE0000, 3};
        vecs[12] = '{1'b0, 4'd7,  32'h00000000, 5, 1'b0, 32'h00000001, 3};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        chk("rel_ready_before_edge", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        chk("rel_ready_first_edge", {31'b0, req_ready}, 32'h1);

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold, vecs[i].exp_err,
                    vecs[i].exp_rdata, vecs[i].exp_lat, (i > 0), $sformatf("vec%0d", i));
            if (vecs[i].we && !vecs[i].exp_err) shadow[vecs[i].addr] = vecs[i].wdata;
        end

        // reset pulsed while a read sits in RD_WAIT
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_rd_wait", {29'b0, dbg_state}, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort_async");
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'b0, rsp_valid}, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 4'd3, 32'h0, 0, 1'b0, 32'hDEADBEEF, 3, 1'b0, "after_abort");

        // random read/write mix against the shadow memory
        for (int r = 0; r < 24; r++) begin
            logic        rwe;
            logic [3:0]  raddr;
            logic [31:0] rwd;
            logic        rerr;
            rwe   = 1'($urandom_range(0, 1));
            raddr = 4'($urandom_range(0, 15));
            rwd   = $urandom;
            rerr  = (raddr >= 4'd8);
            run_txn(rwe, raddr, rwd, $urandom_range(0, 2), rerr,
                    (rwe || rerr) ? 32'h0 : shadow[raddr],
                    rerr ? 1 : (rwe ? 2 : 3), 1'b1, $sformatf("rnd%0d", r));
            if (rwe && !rerr) shadow[raddr] = rwd;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
